// File: rtl/shift_rows_mix_columns_unit_if.sv
// Block handshake bundle for the ShiftRows/MixColumns unit.
// The master side supplies blocks and accepts results; the slave side is the unit.
interface shift_rows_mix_columns_unit_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] state_in;
    logic         final_round;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] state_out;

    modport master (
        output in_valid, state_in, final_round, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, final_round, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/shift_rows_mix_columns_unit.sv
// Forward AES ShiftRows followed by an iterative MixColumns.
// A block is shifted on acceptance, then COLS_PER_CYCLE columns are mixed per
// clock in place. The final round skips mixing and goes straight to DONE.

// One MixColumns column: a0..a3 (rows 0..3) -> b0..b3 over GF(2^8), poly 0x11B.
module shift_rows_mix_columns_lane (
    input  logic [0:3][7:0] a,
    output logic [0:3][7:0] b
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // 3x is folded in as xtime(x) ^ x.
    assign b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
    assign b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
    assign b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
    assign b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
endmodule

module shift_rows_mix_columns_unit #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    shift_rows_mix_columns_unit_if.slave  bus
);
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step; for 4 columns per cycle it wraps to 0 and every MIX edge is the last.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t state, state_nxt;

    // Views indexed [column][row]; byte 0 (row 0, column 0) sits at bit 0 of the bus.
    logic [0:3][0:3][7:0] in_bytes;
    logic [0:3][0:3][7:0] shifted;
    logic [0:3][0:3][7:0] work;
    logic [1:0]           col;

    logic [0:COLS_PER_CYCLE-1][0:3][7:0] mix_in;
    logic [0:COLS_PER_CYCLE-1][0:3][7:0] mix_out;

    assign in_bytes = bus.state_in;

    // Row r rotates left by r columns: out[c][r] = in[(c+r)%4][r].
    generate
        for (genvar c = 0; c < 4; c++) begin : g_sr_col
            for (genvar r = 0; r < 4; r++) begin : g_sr_row
                assign shifted[c][r] = in_bytes[(c + r) % 4][r];
            end
        end
    endgenerate

    // One lane per column handled this cycle; lanes read consecutive columns from col.
    generate
        for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
            assign mix_in[j] = work[col + 2'(j)];
            shift_rows_mix_columns_lane u_lane (
                .a (mix_in[j]),
                .b (mix_out[j])
            );
        end
    endgenerate

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; the final_round decision is captured by the IDLE exit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = bus.final_round ? DONE : MIX;
            MIX:  if (col == LAST_COL) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; result is only exposed while DONE.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.state_out = (state == DONE) ? work : '0;
    end

    // Working register and column counter: load shifted block, then mix in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work <= '0;
            col  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    work <= shifted;
                    col  <= '0;
                end
                MIX: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++)
                        work[col + 2'(j)] <= mix_out[j];
                    col <= col + STEP;
                end
                default: ;
            endcase
        end
    end
endmodule
